uart_send: RTL and testbench

UART_SEND -- requirements
Module: uart_send

---
 rtl/uart_send.sv | 160 ++++++++++++++++
 tb/tb_uart_send.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_send.sv
// uart_send: 4-deep FIFO feeding a UART transmitter, 8N1 frames.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_send #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BPS_LAST = 16'(BPS_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif
  logic [7:0]  mem_q [4];
  logic [1:0]  wptr_q;
  logic [1:0]  rptr_q;
  logic [2:0]  occ_q;
  logic [2:0]  occ_d;
  logic        txd_q;
  logic        busy_q;
  logic        done_q;
  logic        cnt_end;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  assign cnt_end  = (cnt_q == BPS_LAST);
  assign tx_ready = (occ_q != 3'd4);
  assign push     = tx_valid & tx_ready;
  assign head     = mem_q[rptr_q];

  // Popping at the last stop cycle chains frames with no idle gap.
  assign pop = (occ_q != 3'd0) &
               ((state_q == IDLE) |
                ((state_q == STOP) & cnt_end));

  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      occ_q  <= 3'd0;
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
    end else begin
      occ_q <= occ_d;
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wptr_q] <= tx_data;
  end

  // Outputs are registered from the current state, so the line
  // trails the state by one cycle throughout the frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      txd_q  <= 1'b1;
      busy_q <= (state_q != IDLE);
      done_q <= 1'b0;
      if (pop) begin
        shift_q <= head;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^head;
`endif
      end
      unique case (state_q)
        IDLE: begin
          cnt_q <= 16'd0;
          if (pop) state_q <= START;
        end
        START: begin
          txd_q <= 1'b0;
          cnt_q <= cnt_end ? 16'd0 : cnt_q + 16'd1;
          if (cnt_end) begin
            bit_q   <= 3'd0;
            state_q <= DATA;
          end
        end
        DATA: begin
          txd_q <= shift_q[0];
          cnt_q <= cnt_end ? 16'd0 : cnt_q + 16'd1;
          if (cnt_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          txd_q <= par_q;
`else
          txd_q <= 1'b1;
`endif
          cnt_q <= cnt_end ? 16'd0 : cnt_q + 16'd1;
          if (cnt_end) state_q <= STOP;
        end
        STOP: begin
          cnt_q <= cnt_end ? 16'd0 : cnt_q + 16'd1;
          if (cnt_end) begin
            done_q  <= 1'b1;
            state_q <= pop ? START : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: table vectors, corner sequences and random traffic
// checked every cycle against a frame-schedule reference model.
`timescale 1ns/1ps
module tb_uart_send;

  localparam int CLK_FREQ = 1000000;
  localparam int UART_BPS = 100000;
  localparam int B = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic       tx_done;

  uart_send #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int f_start[$];
  logic [7:0] f_data[$];
  int last_end = 0;
  bit m_ready = 1'b1;
  bit chk_en = 1'b0;
  int done_cnt = 0;
  int low_cnt = 0;
  int m_s;
  int m_pend;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == NBITS - 1) return 1'b1;
    return ^d;
  endfunction

  // Each accepted byte gets a frame slot: it starts two edges after
  // acceptance or right when the previous frame ends, whichever is later.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      f_start.delete();
      f_data.delete();
      last_end = 0;
      m_ready = 1'b1;
    end else begin
      cyc++;
      if (tx_valid && m_ready) begin
        m_s = (cyc + 2 > last_end) ? cyc + 2 : last_end;
        f_start.push_back(m_s);
        f_data.push_back(tx_data);
        last_end = m_s + FL;
      end
      m_pend = 0;
      foreach (f_start[i]) if (f_start[i] - 1 > cyc) m_pend++;
      m_ready = (m_pend != 4);
    end
  end

  initial forever begin
    logic e_txd, e_busy, e_done;
    @(negedge clk);
    e_txd = 1'b1;
    e_busy = 1'b0;
    e_done = 1'b0;
    foreach (f_start[i]) begin
      if (cyc >= f_start[i] && cyc < f_start[i] + FL) begin
        e_txd  = frame_bit(f_data[i], (cyc - f_start[i]) / B);
        e_busy = 1'b1;
        e_done = (cyc == f_start[i] + FL - 1);
      end
    end
    if (chk_en) begin
      check($sformatf("txd@%0d", cyc), uart_txd, e_txd);
      check($sformatf("busy@%0d", cyc), tx_busy, e_busy);
      check($sformatf("done@%0d", cyc), tx_done, e_done);
      check($sformatf("ready@%0d", cyc), tx_ready, m_ready);
    end
    if (tx_done) done_cnt++;
    if (!uart_txd) low_cnt++;
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while ((tx_busy || cyc < last_end) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", int'(w < 3000), 1);
  endtask

  task automatic send_one(input logic [7:0] d, input logic p);
    int t0, s, w;
    logic [10:0] bits;
    bits = '1;
    wait_idle();
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
    w = 0;
    while (uart_txd && w < 20) begin
      @(negedge clk);
      w++;
    end
    s = cyc;
    check("latency", s - t0, 2);
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0) repeat (B / 2) @(negedge clk);
      else repeat (B) @(negedge clk);
      bits[k] = uart_txd;
    end
    check("start_bit", bits[0], 0);
    check("data_bits", bits[8:1], d);
`ifdef UART_TX_PARITY_EN
    check("parity_bit", bits[9], p);
`endif
    check("stop_bit", bits[NBITS-1], 1);
    w = 0;
    while (!tx_done && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("done_cycle", cyc - s + 1, FL);
    @(negedge clk);
    check("done_width", tx_done, 0);
    check("busy_after", tx_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int w, gap, d0, low0;
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'hA5, 1'b0};
    vecs[7] = '{8'h01, 1'b1};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", uart_txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ready", tx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) send_one(vecs[i].data, vecs[i].par);

    // Burst of five, then hold a sixth against a full FIFO.
    wait_idle();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data = 8'(i + 1);
    end
    @(negedge clk);
    check("full_ready", tx_ready, 0);
    tx_data = 8'h66;
    gap = 0;
    w = 0;
    while (!tx_done && w < 200) begin
      @(negedge clk);
      w++;
      if (!tx_busy) gap++;
    end
    check("refused_at_stop", tx_ready, 1);
    @(negedge clk);
    check("accepted_next", tx_ready, 0);
    tx_valid = 1'b0;
    while (cyc < last_end - 1 && w < 1000) begin
      @(negedge clk);
      w++;
      if (!tx_busy) gap++;
    end
    check("burst_gaps", gap, 0);
    wait_idle();
    check("burst_dones", done_cnt - d0, 6);

    // Reset during data bit 3 with two bytes still queued.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data = 8'($urandom);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    w = 0;
    while (uart_txd && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (4 * B + 2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_txd", uart_txd, 1);
    check("midrst_ready", tx_ready, 1);
    check("midrst_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low0 = low_cnt;
    repeat (300) @(negedge clk);
    check("no_resume", low_cnt - low0, 0);
    check("no_resume_busy", tx_busy, 0);
    send_one(8'hC3, 1'b0);

    // Random traffic: sparse then heavy.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 99) < ((i < 2000) ? 1 : 25));
      tx_data = 8'($urandom);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
